fc_load_sequencer: RTL and testbench
====================================

// Module: fc_load_sequencer
// PURPOSE
//  Sequences one FC-layer job in the core clock domain. Drains the word stream from the FC AXIS read
//  interface through an internal skid FIFO; weights go to the weight buffer, per-batch activations to
//  the activation buffer; start/done handshake with the MAC core per batch.
//  Owns the almost_full backpressure returned to the read interface.
// PARAMETERS
//  DATA_WIDTH  64  stream / buffer word width
//  W_AW        10  weight buffer address width (max 1024 words)
//  X_AW        8   activation buffer address width (max 256 words)
//  B_W         8   batch counter width
//  SKID_AW     3   skid FIFO address width (depth 8)
//  AF_MARGIN   4   free slots reserved for in-flight words when almost_full asserts
// PORTS
//  core_clk      in   1           core clock (only clock)
//  rst           in   1           reset, asynchronous, active-high
//  in_data       in   DATA_WIDTH  word from read interface
//  in_valid      in   1           word valid; no ready, must be accepted
//  almost_full   out  1           backpressure to read interface
//  cfg_start     in   1           job start pulse; honoured only in IDLE
//  cfg_w_words   in   W_AW+1      weight words, 0 = skip weight load
//  cfg_x_words   in   X_AW+1      activation words per batch, 1..2^X_AW
//  cfg_batches   in   B_W         batch count, 0 = job ends immediately
//  w_wr_en       out  1           weight buffer write strobe
//  w_wr_addr     out  W_AW        weight write address
//  w_wr_data     out  DATA_WIDTH  weight write data
//  x_wr_en       out  1           activation buffer write strobe
//  x_wr_addr     out  X_AW        activation write address
//  x_wr_data     out  DATA_WIDTH  activation write data
//  core_start    out  1           one-cycle compute start per batch
//  core_done     in   1           one-cycle compute completion from MAC core
//  busy          out  1           high whenever state != IDLE
//  job_done      out  1           one-cycle pulse at job end
//  batch_idx     out  B_W         current batch number, 0-based
//  ovf_err       out  1           sticky; word dropped (skid full)
//  cfg_err       out  1           sticky; illegal config at start
// BEHAVIOUR
//  Reset: every output 0, state IDLE, skid FIFO emptied, counters 0. Reset mid-job aborts immediately.
//  Skid: every in_valid word is pushed; at count == depth a new word is dropped, ovf_err <= 1.
//  almost_full = (count >= 2^SKID_AW - AF_MARGIN), combinational from count; covers 2-cycle read latency.
//  Pop: only in LOAD_W / LOAD_X when not empty, max 1 word per cycle; simultaneous push+pop keeps count.
//  Write outputs registered: word pushed at edge N is written to a buffer no earlier than edge N+2.
//  In other states words accumulate in skid until almost_full; none is discarded except on overflow.
//  FSM:
//  IDLE:   cfg_start latches cfg_*. Illegal config (cfg_x_words 0 or > 2^X_AW, cfg_w_words > 2^W_AW):
//          cfg_err <= 1, job_done pulse, stay IDLE. Batches 0 -> job_done, stay IDLE.
//          Otherwise -> LOAD_W if w_words != 0, else -> LOAD_X.
//  LOAD_W: pop -> w_wr_en, addr increments from 0; after w_words-th pop -> LOAD_X.
//  LOAD_X: pop -> x_wr_en, addr restarts at 0 each batch; after x_words-th pop -> START.
//  START:  core_start = 1 for exactly one cycle -> WAIT.
//  WAIT:   on core_done: if batch_idx == batches-1 -> job_done pulse, IDLE; else batch_idx++, -> LOAD_X.
//  core_done outside WAIT is ignored. cfg_start while busy is ignored (no error).
//  Addresses never wrap inside a phase; legal counts guarantee final addr <= 2^AW-1.
//  Word counters W_AW+1 / X_AW+1 bits, so full-depth counts are representable.
// STRUCTURE
//  Package fc_seq_pkg: state enum (IDLE, LOAD_W, LOAD_X, START, WAIT), DATA_WIDTH default.
//  Sub-module fc_skid_fifo: synchronous FIFO, DATA_WIDTH x 2^SKID_AW, exposes count, push/pop, drop flag.
//  FSM, counters and registered write ports live in the top module.
// TESTING
//  1 w=4,x=2,b=1, 6 words back-to-back -> w_wr_addr 0..3, x_wr_addr 0..1, core_start once; job_done after core_done.
//  2 w=0,x=3,b=3, 9 words -> LOAD_W skipped; x addr 0..2 three times; batch_idx 0,1,2; 3 core_start pulses.
//  3 Stream 10 words while IDLE, read side stops 2 cycles after almost_full -> almost_full at count 4, no ovf_err.
//  4 Force 9 words into an IDLE skid -> 9th dropped, ovf_err=1 and sticky; next job runs normally.
//  5 cfg_x_words=0, start -> cfg_err=1, job_done pulse, busy never 1.
//  6 Assert rst during LOAD_X of batch 1 -> all outputs 0, IDLE next edge; fresh job runs correctly.

Source files
------------

// File: rtl/fc_seq_pkg.sv
// Shared types for the FC-layer load sequencer.
package fc_seq_pkg;

   localparam int DATA_WIDTH_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_W,
      ST_LOAD_X,
      ST_START,
      ST_WAIT
   } state_t;

endpackage

// File: rtl/fc_skid_fifo.sv
// Skid FIFO absorbing the un-throttled read stream; full pushes are dropped and flagged.
module fc_skid_fifo
   import fc_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int AW         = 3
) (
   input  logic                  core_clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [AW:0]           count,
   output logic                  empty,
   output logic                  drop
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [DATA_WIDTH-1:0] mem_q [2**AW];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic                  full;
   logic                  push_ok;
   logic                  pop_ok;

   assign full     = (count_q == DEPTH);
   assign empty    = (count_q == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign drop     = push && full;
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge core_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/fc_load_sequencer.sv
// Sequences one FC-layer job: loads weights, then per batch loads activations and
// handshakes with the MAC core. Words arrive through the skid FIFO.
//
// state     | meaning
// ST_IDLE   | waiting for cfg_start; skid keeps filling
// ST_LOAD_W | popping skid words into the weight buffer
// ST_LOAD_X | popping skid words into the activation buffer for batch_idx
// ST_START  | core_start high for this single cycle
// ST_WAIT   | waiting for core_done of the current batch
module fc_load_sequencer
   import fc_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int W_AW       = 10,
   parameter int X_AW       = 8,
   parameter int B_W        = 8,
   parameter int SKID_AW    = 3,
   parameter int AF_MARGIN  = 4
) (
   input  logic                  core_clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  almost_full,
   input  logic                  cfg_start,
   input  logic [W_AW:0]         cfg_w_words,
   input  logic [X_AW:0]         cfg_x_words,
   input  logic [B_W-1:0]        cfg_batches,
   output logic                  w_wr_en,
   output logic [W_AW-1:0]       w_wr_addr,
   output logic [DATA_WIDTH-1:0] w_wr_data,
   output logic                  x_wr_en,
   output logic [X_AW-1:0]       x_wr_addr,
   output logic [DATA_WIDTH-1:0] x_wr_data,
   output logic                  core_start,
   input  logic                  core_done,
   output logic                  busy,
   output logic                  job_done,
   output logic [B_W-1:0]        batch_idx,
   output logic                  ovf_err,
   output logic                  cfg_err
);

   localparam logic [W_AW:0]    W_MAX    = {1'b1, {W_AW{1'b0}}};
   localparam logic [X_AW:0]    X_MAX    = {1'b1, {X_AW{1'b0}}};
   localparam logic [SKID_AW:0] AF_LEVEL = (SKID_AW+1)'((2**SKID_AW) - AF_MARGIN);

   state_t                state_q, state_d;
   logic [W_AW:0]         w_words_q, w_words_d;
   logic [X_AW:0]         x_words_q, x_words_d;
   logic [B_W-1:0]        batches_q, batches_d;
   logic [W_AW:0]         w_cnt_q, w_cnt_d;
   logic [X_AW:0]         x_cnt_q, x_cnt_d;
   logic [B_W-1:0]        batch_idx_q, batch_idx_d;
   logic                  w_wr_en_q, w_wr_en_d;
   logic [W_AW-1:0]       w_wr_addr_q, w_wr_addr_d;
   logic [DATA_WIDTH-1:0] w_wr_data_q, w_wr_data_d;
   logic                  x_wr_en_q, x_wr_en_d;
   logic [X_AW-1:0]       x_wr_addr_q, x_wr_addr_d;
   logic [DATA_WIDTH-1:0] x_wr_data_q, x_wr_data_d;
   logic                  core_start_q, core_start_d;
   logic                  job_done_q, job_done_d;
   logic                  ovf_err_q, ovf_err_d;
   logic                  cfg_err_q, cfg_err_d;

   logic                  fifo_pop;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic [SKID_AW:0]      fifo_count;
   logic                  fifo_empty;
   logic                  fifo_drop;
   logic                  cfg_illegal;

   fc_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (SKID_AW)
   ) u_skid (
      .core_clk  (core_clk),
      .rst       (rst),
      .push      (in_valid),
      .push_data (in_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .drop      (fifo_drop)
   );

   // Threshold leaves room for the words already in flight from the read side.
   assign almost_full = (fifo_count >= AF_LEVEL);

   assign cfg_illegal = (cfg_x_words == '0) || (cfg_x_words > X_MAX) || (cfg_w_words > W_MAX);

   always_comb begin
      state_d      = state_q;
      w_words_d    = w_words_q;
      x_words_d    = x_words_q;
      batches_d    = batches_q;
      w_cnt_d      = w_cnt_q;
      x_cnt_d      = x_cnt_q;
      batch_idx_d  = batch_idx_q;
      w_wr_en_d    = 1'b0;
      w_wr_addr_d  = w_wr_addr_q;
      w_wr_data_d  = w_wr_data_q;
      x_wr_en_d    = 1'b0;
      x_wr_addr_d  = x_wr_addr_q;
      x_wr_data_d  = x_wr_data_q;
      core_start_d = 1'b0;
      job_done_d   = 1'b0;
      ovf_err_d    = ovf_err_q | fifo_drop;
      cfg_err_d    = cfg_err_q;
      fifo_pop     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               w_words_d   = cfg_w_words;
               x_words_d   = cfg_x_words;
               batches_d   = cfg_batches;
               w_cnt_d     = '0;
               x_cnt_d     = '0;
               batch_idx_d = '0;
               if (cfg_illegal) begin
                  cfg_err_d  = 1'b1;
                  job_done_d = 1'b1;
               end else if (cfg_batches == '0) begin
                  job_done_d = 1'b1;
               end else if (cfg_w_words != '0) begin
                  state_d = ST_LOAD_W;
               end else begin
                  state_d = ST_LOAD_X;
               end
            end
         end
         ST_LOAD_W: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               w_wr_en_d   = 1'b1;
               w_wr_addr_d = w_cnt_q[W_AW-1:0];
               w_wr_data_d = fifo_data;
               w_cnt_d     = w_cnt_q + 1'b1;
               if (w_cnt_q + 1'b1 == w_words_q) begin
                  x_cnt_d = '0;
                  state_d = ST_LOAD_X;
               end
            end
         end
         ST_LOAD_X: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               x_wr_en_d   = 1'b1;
               x_wr_addr_d = x_cnt_q[X_AW-1:0];
               x_wr_data_d = fifo_data;
               x_cnt_d     = x_cnt_q + 1'b1;
               if (x_cnt_q + 1'b1 == x_words_q) begin
                  core_start_d = 1'b1;
                  state_d      = ST_START;
               end
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_done) begin
               if (batch_idx_q == batches_q - 1'b1) begin
                  job_done_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  batch_idx_d = batch_idx_q + 1'b1;
                  x_cnt_d     = '0;
                  state_d     = ST_LOAD_X;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         w_words_q    <= '0;
         x_words_q    <= '0;
         batches_q    <= '0;
         w_cnt_q      <= '0;
         x_cnt_q      <= '0;
         batch_idx_q  <= '0;
         w_wr_en_q    <= 1'b0;
         w_wr_addr_q  <= '0;
         w_wr_data_q  <= '0;
         x_wr_en_q    <= 1'b0;
         x_wr_addr_q  <= '0;
         x_wr_data_q  <= '0;
         core_start_q <= 1'b0;
         job_done_q   <= 1'b0;
         ovf_err_q    <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         w_words_q    <= w_words_d;
         x_words_q    <= x_words_d;
         batches_q    <= batches_d;
         w_cnt_q      <= w_cnt_d;
         x_cnt_q      <= x_cnt_d;
         batch_idx_q  <= batch_idx_d;
         w_wr_en_q    <= w_wr_en_d;
         w_wr_addr_q  <= w_wr_addr_d;
         w_wr_data_q  <= w_wr_data_d;
         x_wr_en_q    <= x_wr_en_d;
         x_wr_addr_q  <= x_wr_addr_d;
         x_wr_data_q  <= x_wr_data_d;
         core_start_q <= core_start_d;
         job_done_q   <= job_done_d;
         ovf_err_q    <= ovf_err_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign w_wr_en    = w_wr_en_q;
   assign w_wr_addr  = w_wr_addr_q;
   assign w_wr_data  = w_wr_data_q;
   assign x_wr_en    = x_wr_en_q;
   assign x_wr_addr  = x_wr_addr_q;
   assign x_wr_data  = x_wr_data_q;
   assign core_start = core_start_q;
   assign job_done   = job_done_q;
   assign batch_idx  = batch_idx_q;
   assign ovf_err    = ovf_err_q;
   assign cfg_err    = cfg_err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fc_load_sequencer.sv
// Bench for fc_load_sequencer: config table, skid corner cases, random jobs, mid-job reset.
module tb_fc_load_sequencer;

   localparam int DW   = 64;
   localparam int W_AW = 10;
   localparam int X_AW = 8;
   localparam int B_W  = 8;

   logic            core_clk = 1'b0;
   logic            rst;
   logic [DW-1:0]   in_data;
   logic            in_valid;
   logic            almost_full;
   logic            cfg_start;
   logic [W_AW:0]   cfg_w_words;
   logic [X_AW:0]   cfg_x_words;
   logic [B_W-1:0]  cfg_batches;
   logic            w_wr_en;
   logic [W_AW-1:0] w_wr_addr;
   logic [DW-1:0]   w_wr_data;
   logic            x_wr_en;
   logic [X_AW-1:0] x_wr_addr;
   logic [DW-1:0]   x_wr_data;
   logic            core_start;
   logic            core_done;
   logic            busy;
   logic            job_done;
   logic [B_W-1:0]  batch_idx;
   logic            ovf_err;
   logic            cfg_err;

   fc_load_sequencer dut (
      .core_clk    (core_clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .almost_full (almost_full),
      .cfg_start   (cfg_start),
      .cfg_w_words (cfg_w_words),
      .cfg_x_words (cfg_x_words),
      .cfg_batches (cfg_batches),
      .w_wr_en     (w_wr_en),
      .w_wr_addr   (w_wr_addr),
      .w_wr_data   (w_wr_data),
      .x_wr_en     (x_wr_en),
      .x_wr_addr   (x_wr_addr),
      .x_wr_data   (x_wr_data),
      .core_start  (core_start),
      .core_done   (core_done),
      .busy        (busy),
      .job_done    (job_done),
      .batch_idx   (batch_idx),
      .ovf_err     (ovf_err),
      .cfg_err     (cfg_err)
   );

   always #5 core_clk = ~core_clk;

   typedef struct {
      int   w;
      int   x;
      int   b;
      logic exp_err;
      int   exp_starts;
      bit   exp_busy;
   } vec_t;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] feed_q[$];
   logic [DW-1:0] exp_stream[$];
   int            exp_rd = 0;
   int            w_addr_q[$];
   logic [DW-1:0] w_data_q[$];
   int            x_addr_q[$];
   logic [DW-1:0] x_data_q[$];
   int            x_bidx_q[$];
   int            start_bidx_q[$];
   int            n_done = 0;
   int            busy_cnt = 0;
   bit            seen_b1x = 0;
   bit            chk_af = 0;
   bit            ignore_af = 0;
   int            af_lat = 0;
   int            gap_pct = 0;
   int            m_cnt = 0;
   logic          m_ovf = 1'b0;
   logic          m_cfg = 1'b0;
   bit            af0 = 0, af1 = 0, af2 = 0;
   vec_t          tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Read side: drains feed_q, honouring almost_full with a configurable latency.
   // In IDLE-only phases it also models the skid occupancy and drops.
   task automatic feeder();
      bit stop;
      forever begin
         @(posedge core_clk);
         #1;
         af2 = af1;
         af1 = af0;
         af0 = almost_full;
         if (chk_af) begin
            if (in_valid) begin
               if (m_cnt == 8) begin
                  m_ovf = 1'b1;
                  void'(exp_stream.pop_back());
               end else begin
                  m_cnt++;
               end
            end
            chk("af_level", 64'(almost_full), 64'(m_cnt >= 4));
            chk("ovf_level", 64'(ovf_err), 64'(m_ovf));
         end
         stop = ignore_af ? 1'b0 : ((af_lat == 2) ? af2 : af0);
         if (feed_q.size() > 0 && !stop && $urandom_range(99) >= gap_pct) begin
            in_valid = 1'b1;
            in_data  = feed_q.pop_front();
            exp_stream.push_back(in_data);
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic responder();
      forever begin
         @(negedge core_clk);
         if (core_start === 1'b1 && !rst) begin
            repeat ($urandom_range(1, 4)) @(posedge core_clk);
            #1 core_done = 1'b1;
            @(posedge core_clk);
            #1 core_done = 1'b0;
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge core_clk);
         if (!rst) begin
            if (w_wr_en) begin
               w_addr_q.push_back(int'(w_wr_addr));
               w_data_q.push_back(w_wr_data);
            end
            if (x_wr_en) begin
               x_addr_q.push_back(int'(x_wr_addr));
               x_data_q.push_back(x_wr_data);
               x_bidx_q.push_back(int'(batch_idx));
               if (batch_idx == 1) seen_b1x = 1;
            end
            if (core_start) start_bidx_q.push_back(int'(batch_idx));
            if (job_done) n_done++;
            if (busy) busy_cnt++;
         end
      end
   endtask

   task automatic next_exp(output logic [DW-1:0] d);
      d = (exp_rd < exp_stream.size()) ? exp_stream[exp_rd] : 'x;
      exp_rd++;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({almost_full, w_wr_en, w_wr_addr, x_wr_en, x_wr_addr, core_start,
                               busy, job_done, batch_idx, ovf_err, cfg_err}), 64'(0));
      chk({tag, "_wdata"}, w_wr_data, 64'(0));
      chk({tag, "_xdata"}, x_wr_data, 64'(0));
   endtask

   task automatic run_job(input int w, input int x, input int b, input int n_feed,
                          input logic exp_err, input int exp_starts, input bit exp_busy,
                          input string tag);
      int w0 = w_addr_q.size();
      int x0 = x_addr_q.size();
      int s0 = start_bidx_q.size();
      int d0 = n_done;
      int bz0 = busy_cnt;
      int c = 0;
      int k;
      bit legal = !(x == 0 || x > 256 || w > 1024);
      logic [DW-1:0] d;
      for (int i = 0; i < n_feed; i++) feed_q.push_back({$urandom, $urandom});
      @(posedge core_clk);
      #1;
      cfg_w_words = (W_AW+1)'(w);
      cfg_x_words = (X_AW+1)'(x);
      cfg_batches = B_W'(b);
      cfg_start   = 1'b1;
      @(posedge core_clk);
      #1 cfg_start = 1'b0;
      while (n_done == d0 && c < 20000) begin
         @(posedge core_clk);
         c++;
      end
      if (n_done == d0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no job_done expected job_done within 20000 cycles", tag);
         return;
      end
      repeat (2) @(posedge core_clk);
      @(negedge core_clk);
      m_cfg = exp_err;
      chk({tag, "_cfg_err"}, 64'(cfg_err), 64'(exp_err));
      chk({tag, "_ovf_err"}, 64'(ovf_err), 64'(m_ovf));
      chk({tag, "_done_cnt"}, 64'(n_done - d0), 64'(1));
      chk({tag, "_starts"}, 64'(start_bidx_q.size() - s0), 64'(exp_starts));
      chk({tag, "_busy_seen"}, 64'(busy_cnt > bz0), 64'(exp_busy));
      chk({tag, "_af_drained"}, 64'(almost_full), 64'(0));
      if (legal && b > 0) begin
         chk({tag, "_w_cnt"}, 64'(w_addr_q.size() - w0), 64'(w));
         chk({tag, "_x_cnt"}, 64'(x_addr_q.size() - x0), 64'(x * b));
         for (int i = 0; i < w && w0 + i < w_addr_q.size(); i++) begin
            next_exp(d);
            chk({tag, "_w_addr"}, 64'(w_addr_q[w0 + i]), 64'(i));
            chk({tag, "_w_data"}, w_data_q[w0 + i], d);
         end
         for (int bb = 0; bb < b; bb++) begin
            if (s0 + bb < start_bidx_q.size())
               chk({tag, "_start_bidx"}, 64'(start_bidx_q[s0 + bb]), 64'(bb));
            for (int j = 0; j < x; j++) begin
               k = x0 + bb * x + j;
               if (k < x_addr_q.size()) begin
                  next_exp(d);
                  chk({tag, "_x_addr"}, 64'(x_addr_q[k]), 64'(j));
                  chk({tag, "_x_data"}, x_data_q[k], d);
                  chk({tag, "_x_bidx"}, 64'(x_bidx_q[k]), 64'(bb));
               end
            end
         end
      end
      exp_rd = exp_stream.size();
   endtask

   initial begin
      int w, x, b, c, nf;
      bit legal;
      rst = 1'b1;
      in_data = '0;
      in_valid = 1'b0;
      cfg_start = 1'b0;
      cfg_w_words = '0;
      cfg_x_words = '0;
      cfg_batches = '0;
      core_done = 1'b0;
      fork
         feeder();
         responder();
         monitor();
      join_none

      tbl[0] = '{4, 2, 1, 1'b0, 1, 1};
      tbl[1] = '{0, 3, 3, 1'b0, 3, 1};
      tbl[2] = '{5, 1, 2, 1'b0, 2, 1};
      tbl[3] = '{3, 4, 0, 1'b0, 0, 0};
      tbl[4] = '{1024, 256, 1, 1'b0, 1, 1};
      tbl[5] = '{2, 0, 1, 1'b1, 0, 0};
      tbl[6] = '{2, 257, 1, 1'b1, 0, 0};
      tbl[7] = '{1025, 1, 1, 1'b1, 0, 0};

      repeat (3) @(posedge core_clk);
      @(negedge core_clk);
      check_zero("reset");
      @(posedge core_clk);
      #1 rst = 1'b0;

      gap_pct = 20;
      foreach (tbl[i]) begin
         legal = !(tbl[i].x == 0 || tbl[i].x > 256 || tbl[i].w > 1024);
         nf = (legal && tbl[i].b > 0) ? tbl[i].w + tbl[i].x * tbl[i].b : 0;
         run_job(tbl[i].w, tbl[i].x, tbl[i].b, nf, tbl[i].exp_err, tbl[i].exp_starts,
                 tbl[i].exp_busy, $sformatf("tbl%0d", i));
      end

      // Read side reacts to almost_full two cycles late: skid peaks at 6, no drop.
      gap_pct = 0;
      m_cnt = 0;
      af_lat = 2;
      chk_af = 1;
      for (int i = 0; i < 10; i++) feed_q.push_back({$urandom, $urandom});
      repeat (20) @(posedge core_clk);
      @(negedge core_clk);
      chk("af_lat_af", 64'(almost_full), 64'(1));
      chk("af_lat_ovf", 64'(ovf_err), 64'(0));
      chk("af_lat_left", 64'(feed_q.size()), 64'(4));
      chk_af = 0;
      af_lat = 0;
      run_job(6, 4, 1, 0, m_cfg, 1, 1, "af_job");

      // Nine words forced into an idle skid: the ninth is lost.
      m_cnt = 0;
      ignore_af = 1;
      chk_af = 1;
      for (int i = 0; i < 9; i++) feed_q.push_back({$urandom, $urandom});
      repeat (15) @(posedge core_clk);
      @(negedge core_clk);
      chk("ovf_sticky", 64'(ovf_err), 64'(1));
      chk_af = 0;
      ignore_af = 0;
      run_job(4, 4, 1, 0, m_cfg, 1, 1, "ovf_job");

      for (int r = 0; r < 6; r++) begin
         gap_pct = $urandom_range(0, 50);
         w = $urandom_range(0, 12);
         x = $urandom_range(1, 8);
         b = $urandom_range(1, 4);
         run_job(w, x, b, w + x * b, m_cfg, b, 1, $sformatf("rnd%0d", r));
      end

      // Reset during batch 1 activation load.
      gap_pct = 10;
      seen_b1x = 0;
      for (int i = 0; i < 11; i++) feed_q.push_back({$urandom, $urandom});
      @(posedge core_clk);
      #1;
      cfg_w_words = 11'd2;
      cfg_x_words = 9'd3;
      cfg_batches = 8'd3;
      cfg_start = 1'b1;
      @(posedge core_clk);
      #1 cfg_start = 1'b0;
      c = 0;
      while (!seen_b1x && c < 2000) begin
         @(posedge core_clk);
         c++;
      end
      chk("rst_reached_b1", 64'(seen_b1x), 64'(1));
      feed_q.delete();
      @(posedge core_clk);
      #3 rst = 1'b1;
      #1 check_zero("rst_mid");
      repeat (2) @(posedge core_clk);
      #1 rst = 1'b0;
      exp_rd = exp_stream.size();
      m_ovf = 1'b0;
      m_cfg = 1'b0;
      @(negedge core_clk);
      chk("rst_idle", 64'(busy), 64'(0));
      run_job(3, 2, 2, 7, 1'b0, 2, 1, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
